// File: rtl/chess_clock_pkg.sv
// Shared constants for the chess-clock display path: glyphs, converter states, count width.
package chess_clock_pkg;

  localparam int CNT_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH
  } conv_state_e;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;

  // Decimal glyphs 0-9. Codes 10-15 cannot come out of the converter and stay dark.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    return SEG_GLYPH[d];
  endfunction

endpackage

// File: rtl/chess_clock_seg_driver_if.sv
// Timer-to-display bundle: tick count, player select and timeout flag in; LED pins out.
interface chess_clock_seg_driver_if;
  import chess_clock_pkg::*;

  logic [CNT_W-1:0] cnt_dis;
  logic             win;
  logic             seg_en;
  logic [3:0]       an;
  logic [6:0]       seg;
  logic             dp;

  modport master (output cnt_dis, win, seg_en, input an, seg, dp);
  modport slave  (input cnt_dis, win, seg_en, output an, seg, dp);
endinterface

// File: rtl/bcd_serial_conv.sv
// Serial double-dabble converter: IDLE capture, CNT_W shift cycles, LATCH; free-running loop.
module bcd_serial_conv
  import chess_clock_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             win_in,
  output logic [11:0]      bcd,
  output logic             win_out,
  output logic             valid
);

  localparam logic [3:0] SHIFT_LAST = 4'(CNT_W - 1);

  conv_state_e      state, state_next;
  logic [3:0]       shift_cnt;
  logic [CNT_W-1:0] shadow;
  logic             shadow_win;
  logic [11:0]      acc, acc_adj;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register updates from the same pre-edge values.
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE:  state_next = ST_SHIFT;
      ST_SHIFT: if (shift_cnt == SHIFT_LAST) state_next = ST_LATCH;
      ST_LATCH: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Add-3 correction on each nibble before the shift keeps every digit in 0..9.
  always_comb begin
    acc_adj = acc;
    for (int n = 0; n < 3; n++) begin
      if (acc[n*4 +: 4] >= 4'd5) acc_adj[n*4 +: 4] = acc[n*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: every register here is reset, so a reset mid-conversion leaves a clean snapshot.
    if (rst) begin
      shift_cnt  <= '0;
      shadow     <= '0;
      shadow_win <= 1'b0;
      acc        <= '0;
      bcd        <= '0;
      win_out    <= 1'b0;
      valid      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          shadow     <= cnt_in;
          shadow_win <= win_in;
          acc        <= '0;
          shift_cnt  <= '0;
        end
        ST_SHIFT: begin
          acc       <= 12'({acc_adj, shadow[CNT_W-1]});
          shadow    <= {shadow[CNT_W-2:0], 1'b0};
          shift_cnt <= shift_cnt + 4'd1;
        end
        ST_LATCH: begin
          bcd     <= acc;
          win_out <= shadow_win;
          valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/chess_clock_seg_driver.sv
// Drives a 4-digit common-anode display as "P SS.T" with digit scan and timeout blink.
module chess_clock_seg_driver
  import chess_clock_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                     clk,
  input  logic                     rst,
  chess_clock_seg_driver_if.slave  bus
);

  localparam int SCAN_W  = $clog2(SCAN_DIV + 1);
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [11:0]        disp_bcd;
  logic               disp_win;
  logic               conv_valid;
  logic [SCAN_W-1:0]  scan_pre;
  logic [1:0]         scan_idx;
  logic [BLINK_W-1:0] blink_pre;
  logic               blink_phase;
  logic [6:0]         seg_next;
  logic               dp_next;

  bcd_serial_conv u_conv (
    .clk     (clk),
    .rst     (rst),
    .cnt_in  (bus.cnt_dis),
    .win_in  (bus.win),
    .bcd     (disp_bcd),
    .win_out (disp_win),
    .valid   (conv_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_pre <= '0;
      scan_idx <= '0;
    end else if (scan_pre == SCAN_LAST) begin
      scan_pre <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      scan_pre <= scan_pre + 1'b1;
    end
  end

  // Blink state is held clear whenever the turn has not expired.
  always_ff @(posedge clk) begin
    if (rst || !bus.seg_en) begin
      blink_pre   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_pre == BLINK_LAST) begin
      blink_pre   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_pre <= blink_pre + 1'b1;
    end
  end

  always_comb begin
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    case (scan_idx)
      2'd3: seg_next = disp_win ? SEG_B : SEG_A;
      2'd2: seg_next = (disp_bcd[11:8] == 4'd0) ? SEG_BLANK : seg_glyph(disp_bcd[11:8]);
      2'd1: begin
        seg_next = seg_glyph(disp_bcd[7:4]);
        dp_next  = 1'b0;
      end
      default: seg_next = seg_glyph(disp_bcd[3:0]);
    endcase
  end

  // Anode, segments and dp share one register stage so digits never ghost.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.an  <= 4'b1111;
      bus.seg <= SEG_BLANK;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= (bus.seg_en && blink_phase) ? 4'b1111 : ~(4'b0001 << scan_idx);
      bus.seg <= seg_next;
      bus.dp  <= dp_next;
    end
  end

endmodule
